tms_stim_sequencer: RTL

Stimulation sequencer that drives one IGBT charge path and one SCR discharge path for single, repetitive (rTMS) and burst (TBS) stimulation. Each pulse runs charge → dead time → period wait → SCR fire. It sits above the IGBT/SCR pulse-enable logic and replaces key-driven enables with timed, interlocked sequences, selecting one of two channels per run. Charge timeout and driver faults abort the run safely.

---
 rtl/tms_stim_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tms_stim_sequencer.sv
// Interlocked IGBT-charge / SCR-fire sequencer for single, repetitive and burst stimulation.
// Registered outputs follow the sampling edge; abort/fault force everything off on the next edge.
module tms_stim_sequencer #(
    parameter int unsigned TICK_DIV          = 50,
    parameter int unsigned SCR_PULSE_US      = 200,
    parameter int unsigned DEAD_US           = 10,
    parameter int unsigned CHARGE_TIMEOUT_US = 100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic        channel,
    input  logic [23:0] ipi_us,
    input  logic [23:0] ibi_us,
    input  logic [3:0]  pulses_per_burst,
    input  logic [11:0] train_count,
    input  logic [1:0]  cap_ready,
    input  logic        driver_fault,
    output logic [1:0]  igbt_charge_en,
    output logic [1:0]  scr_fire,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_fault,
    output logic [11:0] pulse_idx
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, CHARGE, DEAD1, ARM, FIRE, DEAD2} state_t;

    state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [23:0] st_q, per_q, bur_q, ipi_q, ibi_q;
    logic [1:0]  mode_q;
    logic        ch_q, fired_q;
    logic [3:0]  ppb_q, in_burst_q;
    logic [11:0] train_q, bursts_q, pulse_idx_q;
    logic [1:0]  igbt_q, scr_q;
    logic        busy_q, done_q, err_to_q, err_f_q;

    logic        tick, launch, fire_entry, done_d, timeout_d, fault_d;
    logic        period_ok, run_done, ch_d;
    logic [31:0] st_nxt;
    logic [1:0]  ch_mask;

    assign tick    = (div_q == DIV_MAX);
    assign st_nxt  = {8'd0, st_q} + 32'd1;
    assign ch_d    = launch ? channel : ch_q;
    assign ch_mask = ch_d ? 2'b10 : 2'b01;

    // First pulse of a run never waits; first pulse of each later burst uses the burst period.
    always_comb begin
        period_ok = 1'b1;
        run_done  = 1'b1;
        unique case (mode_q)
            2'd1: begin
                period_ok = !fired_q || (per_q >= ipi_q);
                run_done  = (pulse_idx_q >= train_q);
            end
            2'd2: begin
                period_ok = !fired_q || ((in_burst_q == 4'd0) ? (bur_q >= ibi_q) : (per_q >= ipi_q));
                run_done  = (bursts_q >= train_q);
            end
            default: begin
                period_ok = 1'b1;
                run_done  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        fire_entry = 1'b0;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        fault_d    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = CHARGE;
                launch  = 1'b1;
            end
            CHARGE: begin
                if (tick && st_nxt >= CHARGE_TIMEOUT_US) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (cap_ready[ch_q]) begin
                    state_d = DEAD1;
                end
            end
            DEAD1: if (tick && st_nxt >= DEAD_US) state_d = ARM;
            ARM: if (period_ok) begin
                state_d    = FIRE;
                fire_entry = 1'b1;
            end
            FIRE: if (tick && st_nxt >= SCR_PULSE_US) state_d = DEAD2;
            DEAD2: if (tick && st_nxt >= DEAD_US) begin
                if (run_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CHARGE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && (driver_fault || abort)) begin
            state_d    = IDLE;
            fault_d    = driver_fault;
            timeout_d  = 1'b0;
            done_d     = 1'b0;
            fire_entry = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            st_q        <= '0;
            per_q       <= '0;
            bur_q       <= '0;
            ipi_q       <= '0;
            ibi_q       <= '0;
            mode_q      <= '0;
            ch_q        <= 1'b0;
            fired_q     <= 1'b0;
            ppb_q       <= '0;
            in_burst_q  <= '0;
            train_q     <= '0;
            bursts_q    <= '0;
            pulse_idx_q <= '0;
            igbt_q      <= '0;
            scr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= (launch || tick) ? '0 : div_q + 1'b1;
            st_q    <= (launch || state_d != state_q) ? '0 : (tick ? st_q + 24'd1 : st_q);

            if (launch || fire_entry) per_q <= '0;
            else if (tick && per_q != '1) per_q <= per_q + 24'd1;

            if (launch || (fire_entry && in_burst_q == 4'd0)) bur_q <= '0;
            else if (tick && bur_q != '1) bur_q <= bur_q + 24'd1;

            if (launch) begin
                mode_q      <= mode;
                ch_q        <= channel;
                ipi_q       <= ipi_us;
                ibi_q       <= ibi_us;
                ppb_q       <= (pulses_per_burst == 4'd0) ? 4'd1 : pulses_per_burst;
                train_q     <= (train_count == 12'd0) ? 12'd1 : train_count;
                fired_q     <= 1'b0;
                in_burst_q  <= '0;
                bursts_q    <= '0;
                pulse_idx_q <= '0;
                err_to_q    <= 1'b0;
                err_f_q     <= 1'b0;
            end else begin
                if (fire_entry) begin
                    fired_q     <= 1'b1;
                    pulse_idx_q <= pulse_idx_q + 12'd1;
                    if (in_burst_q + 4'd1 >= ppb_q) begin
                        in_burst_q <= '0;
                        bursts_q   <= bursts_q + 12'd1;
                    end else begin
                        in_burst_q <= in_burst_q + 4'd1;
                    end
                end
                if (timeout_d) err_to_q <= 1'b1;
                if (fault_d)   err_f_q  <= 1'b1;
            end

            igbt_q <= (state_d == CHARGE) ? ch_mask : 2'b00;
            scr_q  <= (state_d == FIRE)   ? ch_mask : 2'b00;
            busy_q <= (state_d != IDLE);
            done_q <= done_d;
        end
    end

    assign igbt_charge_en = igbt_q;
    assign scr_fire       = scr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_timeout    = err_to_q;
    assign err_fault      = err_f_q;
    assign pulse_idx      = pulse_idx_q;

endmodule
